// File: rtl/sm_colour_pkg.sv
// ============================================================================
// Module      : sm_colour_pkg
// Description : Colour event codes, filter FSM states and the flag decoder
//               shared by the colour event filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sm_colour_pkg;

    localparam logic [1:0] COL_NONE  = 2'b00;
    localparam logic [1:0] COL_RED   = 2'b01;
    localparam logic [1:0] COL_BLUE  = 2'b10;
    localparam logic [1:0] COL_GREEN = 2'b11;

    typedef enum logic [0:0] {
        ST_ARMED    = 1'b0,
        ST_DISARMED = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;  // exactly one flag set
        logic       none;   // no flag set
        logic [1:0] code;
    } sample_t;

    // Two or more flags set decodes as neither valid nor none (INVALID).
    function automatic sample_t decode_colour(input logic [2:0] flags);
        sample_t result;
        result = '0;
        case (flags)
            3'b001:  begin result.valid = 1'b1; result.code = COL_RED;   end
            3'b010:  begin result.valid = 1'b1; result.code = COL_BLUE;  end
            3'b100:  begin result.valid = 1'b1; result.code = COL_GREEN; end
            3'b000:  result.none = 1'b1;
            default: result = '0;
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sm_event_fifo.sv
// ============================================================================
// Module      : sm_event_fifo
// Description : Small synchronous FIFO; a push into a full FIFO is accepted
//               only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_event_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_level == c_FULL_LEVEL);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
            else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sm_colour_event_filter.sv
// ============================================================================
// Module      : sm_colour_event_filter
// Description : Samples colour flags, debounces them and queues one event per
//               confirmed colour; the colour must vanish before re-arming.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_colour_event_filter
    import sm_colour_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int STABLE_CNT = 3,
    parameter int REARM_CNT  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    color_in,
    output logic                          out_valid,
    output logic [1:0]                    out_colour,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    event_total
);

    localparam int DIV_W   = $clog2(SAMPLE_DIV + 1);
    localparam int RUN_W   = $clog2(STABLE_CNT + 1);
    localparam int REARM_W = $clog2(REARM_CNT + 1);

    localparam logic [DIV_W-1:0]   c_DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RUN_W-1:0]   c_RUN_DONE   = RUN_W'(STABLE_CNT);
    localparam logic [REARM_W-1:0] c_REARM_DONE = REARM_W'(REARM_CNT);

    logic [DIV_W-1:0]   r_div;
    state_t             r_state, w_state_nxt;
    logic [RUN_W-1:0]   r_run, w_run_nxt;
    logic [1:0]         r_last, w_last_nxt;
    logic [REARM_W-1:0] r_rearm, w_rearm_nxt;
    logic               r_overflow;
    logic [7:0]         r_event_total;

    logic               w_tick;
    sample_t            w_sample;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [1:0]         w_head;

    assign w_tick   = (r_div == c_DIV_LAST);
    assign w_sample = decode_colour(color_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_state       <= ST_ARMED;
            r_run         <= '0;
            r_last        <= COL_NONE;
            r_rearm       <= '0;
            r_overflow    <= 1'b0;
            r_event_total <= '0;
        end else begin
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_last  <= w_last_nxt;
            r_rearm <= w_rearm_nxt;
            // A push into a full FIFO survives only if the head leaves this cycle.
            if (w_push && (!w_full || w_pop)) begin
                r_event_total <= r_event_total + 1'b1;
            end else if (w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_last_nxt  = r_last;
        w_rearm_nxt = r_rearm;
        w_push      = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_ARMED: begin
                    if (w_sample.valid) begin
                        if (w_sample.code == r_last && r_run != '0) begin
                            w_run_nxt = r_run + 1'b1;
                        end else begin
                            w_run_nxt  = RUN_W'(1);
                            w_last_nxt = w_sample.code;
                        end
                        if (w_run_nxt == c_RUN_DONE) begin
                            w_push      = 1'b1;
                            w_state_nxt = ST_DISARMED;
                            w_rearm_nxt = '0;
                        end
                    end else begin
                        w_run_nxt  = '0;
                        w_last_nxt = COL_NONE;
                    end
                end
                ST_DISARMED: begin
                    if (w_sample.none) begin
                        w_rearm_nxt = r_rearm + 1'b1;
                        if (w_rearm_nxt == c_REARM_DONE) begin
                            w_state_nxt = ST_ARMED;
                            w_run_nxt   = '0;
                            w_last_nxt  = COL_NONE;
                            w_rearm_nxt = '0;
                        end
                    end else begin
                        w_rearm_nxt = '0;
                    end
                end
                default: w_state_nxt = ST_ARMED;
            endcase
        end
    end

    assign w_pop = out_valid & out_ready;

    sm_event_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_last_nxt),
        .pop       (w_pop),
        .rd_data   (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    assign out_valid   = ~w_empty;
    assign out_colour  = out_valid ? w_head : COL_NONE;
    assign overflow    = r_overflow;
    assign event_total = r_event_total;

endmodule

`default_nettype wire

// File: tb/tb_sm_colour_event_filter.sv
// ============================================================================
// Module      : tb_sm_colour_event_filter
// Description : Directed plus random stimulus against a sample-history model
//               of the colour event filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm_colour_event_filter;

    localparam int SDIV   = 4;
    localparam int STABLE = 3;
    localparam int REARM  = 3;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] color_in = 3'b000;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [1:0] out_colour;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] event_total;

    int total = 0;
    int bad   = 0;

    // Reference state: cycles since reset, samples seen since the last mode change.
    int         m_cyc;
    bit         m_armed;
    logic [2:0] m_hist[$];
    logic [1:0] m_q[$];
    bit         m_ovf;
    logic [7:0] m_tot;

    sm_colour_event_filter #(
        .SAMPLE_DIV (SDIV),
        .STABLE_CNT (STABLE),
        .REARM_CNT  (REARM),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .color_in    (color_in),
        .out_valid   (out_valid),
        .out_colour  (out_colour),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .event_total (event_total)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] code_of(input logic [2:0] s);
        case (s)
            3'b001:  return 2'b01;
            3'b010:  return 2'b10;
            3'b100:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit tail_all(input int n, input logic [2:0] v);
        int sz = m_hist.size();
        if (sz < n) return 0;
        for (int k = sz - n; k < sz; k++) if (m_hist[k] !== v) return 0;
        return 1;
    endfunction

    task automatic model_edge(input logic [2:0] col, input logic rdy, input logic r);
        bit         pop;
        bit         push;
        logic [1:0] pcode;
        if (r) begin
            m_cyc = 0; m_armed = 1; m_hist.delete(); m_q.delete();
            m_ovf = 0; m_tot = 8'd0;
            return;
        end
        pop   = (m_q.size() > 0) && rdy;
        push  = 0;
        pcode = 2'b00;
        if (m_cyc % SDIV == SDIV - 1) begin
            m_hist.push_back(col);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
            if (m_armed) begin
                if (code_of(col) != 2'b00 && tail_all(STABLE, col)) begin
                    push = 1; pcode = code_of(col); m_armed = 0; m_hist.delete();
                end
            end else if (tail_all(REARM, 3'b000)) begin
                m_armed = 1; m_hist.delete();
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(pcode);
                m_tot = m_tot + 8'd1;
            end else begin
                m_ovf = 1;
            end
        end
        m_cyc++;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h time=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input logic [2:0] col, input logic rdy);
        logic [1:0] exp_col;
        color_in  = col;
        out_ready = rdy;
        model_edge(col, rdy, rst);
        @(posedge clk);
        #1;
        exp_col = (m_q.size() > 0) ? m_q[0] : 2'b00;
        check("out_valid",   8'(out_valid),   8'(m_q.size() > 0));
        check("out_colour",  8'(out_colour),  8'(exp_col));
        check("fifo_level",  8'(fifo_level),  8'(m_q.size()));
        check("overflow",    8'(overflow),    8'(m_ovf));
        check("event_total", event_total,     m_tot);
    endtask

    task automatic ticks(input logic [2:0] col, input logic rdy, input int n);
        repeat (n * SDIV) cycle(col, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle(3'b000, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] col;
        logic [2:0] seq [5];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
        seq[3] = 3'b001; seq[4] = 3'b010;

        // Reset state.
        do_reset();

        // Single red event, then a long hold must not repeat it.
        ticks(3'b001, 1'b0, 3);
        ticks(3'b001, 1'b0, 10);
        ticks(3'b000, 1'b0, 3);
        ticks(3'b001, 1'b0, 3);
        ticks(3'b000, 1'b1, 3);

        // Run restarts on colour change; a multi-flag sample clears the run.
        ticks(3'b010, 1'b1, 2);
        ticks(3'b100, 1'b1, 3);
        ticks(3'b000, 1'b1, 3);
        ticks(3'b100, 1'b1, 2);
        ticks(3'b011, 1'b1, 1);
        ticks(3'b100, 1'b1, 2);
        ticks(3'b000, 1'b1, 3);

        // Five events with no consumer: overflow, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ticks(seq[i], 1'b0, 3);
            ticks(3'b000, 1'b0, 3);
        end
        repeat (6) cycle(3'b000, 1'b1);

        // Full FIFO with a pop on the very cycle of the push.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ticks(seq[i], 1'b0, 3);
            ticks(3'b000, 1'b0, 3);
        end
        ticks(3'b010, 1'b0, 2);
        while (m_cyc % SDIV != SDIV - 1) cycle(3'b010, 1'b0);
        cycle(3'b010, 1'b1);
        ticks(3'b000, 1'b0, 3);

        // Reset mid-run with a non-empty FIFO; a fresh event needs three ticks.
        ticks(3'b100, 1'b0, 2);
        rst = 1'b1;
        cycle(3'b100, 1'b0);
        rst = 1'b0;
        ticks(3'b100, 1'b0, 2);
        ticks(3'b100, 1'b0, 2);
        repeat (3) cycle(3'b000, 1'b1);

        // Random sample streams with a sporadic consumer.
        col = 3'b000;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) < 4) col = 3'($urandom_range(0, 7));
            for (int c = 0; c < SDIV; c++) cycle(col, 1'($urandom_range(0, 9) < 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
